// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// FSM state encodings and the default operand width.
package serial_subtractor_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor built from two half subtractors.
// d = a - b - bin, bout set when the step needs to borrow.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   // Difference and borrow of a single a - b step
   always_comb begin
      d    = a ^ b;
      bout = ~a & b;
   end

endmodule

module full_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic b1;
   logic b2;

   half_subtractor u_hs0 (
      .a    (a),
      .b    (b),
      .d    (d1),
      .bout (b1)
   );

   half_subtractor u_hs1 (
      .a    (d1),
      .b    (bin),
      .d    (d),
      .bout (b2)
   );

   // Either stage borrowing means the cell borrows
   always_comb begin
      bout = b1 | b2;
   end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B, LSB first, one full-subtractor step per clock.
// start/busy/done handshake; Y and borrow held between results.
module serial_subtractor_ctrl
   import serial_subtractor_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    cnt;
   logic             bff;
   logic             d;
   logic             bout;

   full_subtractor_cell u_cell (
      .a    (areg[0]),
      .b    (breg[0]),
      .bin  (bff),
      .d    (d),
      .bout (bout)
   );

   // Sequencer: capture, shift one bit per cycle, publish result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         areg   <= '0;
         breg   <= '0;
         res    <= '0;
         cnt    <= '0;
         bff    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Y      <= '0;
         borrow <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  areg  <= A;
                  breg  <= B;
                  res   <= '0;
                  cnt   <= '0;
                  bff   <= 1'b0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               res  <= {d, res[WIDTH-1:1]};
               areg <= {1'b0, areg[WIDTH-1:1]};
               breg <= {1'b0, breg[WIDTH-1:1]};
               bff  <= bout;
               if (cnt == LAST) begin
                  Y      <= {d, res[WIDTH-1:1]};
                  borrow <= bout;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl at WIDTH=8 and 4.
// Stimulus queues expectations; monitors compare on each done.
module tb_serial_subtractor_ctrl;

   localparam int W  = 8;
   localparam int W4 = 4;

   typedef struct {
      logic [7:0] y;
      logic       bo;
      int         cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] y;
   logic         borrow;

   logic          s4 = 1'b0;
   logic [W4-1:0] a4 = '0;
   logic [W4-1:0] b4 = '0;
   logic          busy4;
   logic          done4;
   logic [W4-1:0] y4;
   logic          bo4;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   bcnt = 0;
   exp_t q8[$];
   exp_t q4[$];

   serial_subtractor_ctrl #(.WIDTH(W)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (a),
      .B      (b),
      .busy   (busy),
      .done   (done),
      .Y      (y),
      .borrow (borrow)
   );

   serial_subtractor_ctrl #(.WIDTH(W4)) u_dut4 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (s4),
      .A      (a4),
      .B      (b4),
      .busy   (busy4),
      .done   (done4),
      .Y      (y4),
      .borrow (bo4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // WIDTH=8 monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         bcnt = 0;
      end else begin
         if (busy) bcnt++;
         if (done) begin
            if (q8.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = q8.pop_front();
               chk("y", int'(y), int'(e.y));
               chk("borrow", int'(borrow), int'(e.bo));
               chk("latency", cyc, e.cyc);
               chk("busy_cycles", bcnt, W);
               chk("busy_in_done", int'(busy), 0);
            end
            bcnt = 0;
         end
      end
   end

   // WIDTH=4 monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done4) begin
         if (q4.size() == 0) begin
            chk("unexpected_done4", 1, 0);
         end else begin
            e = q4.pop_front();
            chk("y4", int'(y4), int'(e.y[3:0]));
            chk("borrow4", int'(bo4), int'(e.bo));
            chk("latency4", cyc, e.cyc);
         end
      end
   end

   task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ey, input logic eb);
      @(posedge clk);
      #1;
      start = 1'b1;
      a = av;
      b = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
      q8.push_back('{ey, eb, cyc + W});
      repeat (W + 1) @(posedge clk);
   endtask

   task automatic op4(input logic [3:0] av, input logic [3:0] bv);
      logic [3:0] ey;
      ey = av - bv;
      @(posedge clk);
      #1;
      s4 = 1'b1;
      a4 = av;
      b4 = bv;
      @(posedge clk);
      #1;
      s4 = 1'b0;
      q4.push_back('{{4'h0, ey}, av < bv, cyc + W4});
      repeat (W4 + 1) @(posedge clk);
   endtask

   logic [7:0] hv_a [4] = '{8'h35, 8'h12, 8'h00, 8'hFF};
   logic [7:0] hv_b [4] = '{8'h12, 8'h35, 8'h01, 8'hFF};
   logic [7:0] hv_y [4] = '{8'h23, 8'hDD, 8'hFF, 8'h00};
   logic       hv_o [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      #2;
      chk("rst_y", int'(y), 0);
      chk("rst_borrow", int'(borrow), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      op8(8'h35, 8'h12, 8'h23, 1'b0);
      op8(8'h12, 8'h35, 8'hDD, 1'b1);
      op8(8'h00, 8'h01, 8'hFF, 1'b1);
      op8(8'hFF, 8'hFF, 8'h00, 1'b0);
      op8(8'h80, 8'h7F, 8'h01, 1'b0);

      // second start mid-operation must be ignored
      @(posedge clk);
      #1;
      start = 1'b1;
      a = 8'h80;
      b = 8'h01;
      @(posedge clk);
      #1;
      start = 1'b0;
      q8.push_back('{8'h7F, 1'b0, cyc + W});
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      a = 8'hFF;
      b = 8'h00;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (W - 2) @(posedge clk);

      // reset in the middle of an operation
      @(posedge clk);
      #1;
      start = 1'b1;
      a = 8'h35;
      b = 8'h12;
      @(posedge clk);
      #1;
      start = 1'b0;
      q8.push_back('{8'h23, 1'b0, cyc + W});
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_y", int'(y), 0);
      chk("midrst_borrow", int'(borrow), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      void'(q8.pop_back());
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      op8(8'h0A, 8'h03, 8'h07, 1'b0);

      // start held high: one accept every W+2 cycles
      @(posedge clk);
      #1;
      start = 1'b1;
      a = hv_a[0];
      b = hv_b[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         q8.push_back('{hv_y[i], hv_o[i], cyc + W});
         if (i < 3) begin
            a = hv_a[i + 1];
            b = hv_b[i + 1];
         end else begin
            start = 1'b0;
         end
         repeat (W + 1) @(posedge clk);
      end

      // exhaustive sweep at WIDTH=4
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            op4(4'(i), 4'(j));

      fork
         wait (q8.size() == 0 && q4.size() == 0);
         repeat (200) @(posedge clk);
      join_any
      disable fork;
      chk("queue_drain", q8.size() + q4.size(), 0);
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
